// File: rtl/gpio_ext_if.sv
// Register-bus bundle for gpio_ext: one-cycle request pulse, response strobe one cycle later.
interface gpio_ext_if;
    logic        bus_req;
    logic        bus_we;
    logic [11:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/gpio_ext.sv
// Parametrised GPIO controller: synchronised inputs, set/clear output access, edge interrupts.
// Define GPIO_DEBOUNCE_EN to build the prescaled input debounce filter and its DBR register.
module gpio_ext #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    gpio_ext_if.slave        bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [11:0] ADDR_CR   = 12'h000;
    localparam logic [11:0] ADDR_SR   = 12'h004;
    localparam logic [11:0] ADDR_ODR  = 12'h008;
    localparam logic [11:0] ADDR_IDR  = 12'h00c;
    localparam logic [11:0] ADDR_IER  = 12'h010;
    localparam logic [11:0] ADDR_ISR  = 12'h014;
    localparam logic [11:0] ADDR_RIER = 12'h018;
    localparam logic [11:0] ADDR_FIER = 12'h01c;
    localparam logic [11:0] ADDR_OENR = 12'h020;
    localparam logic [11:0] ADDR_BSR  = 12'h024;
    localparam logic [11:0] ADDR_BCR  = 12'h028;
    localparam logic [11:0] ADDR_DBR  = 12'h02c;

    logic                                r_cr;
    logic [WIDTH-1:0]                    r_odr;
    logic [WIDTH-1:0]                    r_oenr;
    logic [WIDTH-1:0]                    r_ier;
    logic [WIDTH-1:0]                    r_isr;
    logic [WIDTH-1:0]                    r_rier;
    logic [WIDTH-1:0]                    r_fier;
    logic [WIDTH-1:0]                    r_idr;
    logic [WIDTH-1:0]                    r_idr_d;
    logic                                r_primed;
    logic                                r_irq;
    logic                                r_rvalid;
    logic [31:0]                         r_rdata;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   r_sync;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_qedge;
    logic [WIDTH-1:0] w_w1c;
    logic             w_sr;
    logic [31:0]      w_dbr_rd;
    logic [31:0]      w_rdata;

    assign w_wr   = bus.bus_req & bus.bus_we;
    assign w_rd   = bus.bus_req & ~bus.bus_we;
    assign w_wd   = bus.bus_wdata[WIDTH-1:0];
    assign w_sync = r_sync[SYNC_STAGES-1];

    // Pad inputs are asynchronous; entry 0 is the first metastability flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0]      r_dbr;
    logic [15:0]      r_presc;
    logic [WIDTH-1:0] r_samp;
    logic             w_tick;
    logic             w_bypass;
    logic             w_wr_dbr;

    assign w_wr_dbr = w_wr && (bus.bus_addr == ADDR_DBR);
    assign w_tick   = (r_presc == 16'd0);
    assign w_bypass = (r_dbr == 16'd0);
    assign w_dbr_rd = {16'd0, r_dbr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dbr   <= '0;
            r_presc <= '0;
            r_samp  <= '0;
        end else begin
            if (w_wr_dbr) begin
                r_dbr   <= bus.bus_wdata[15:0];
                r_presc <= bus.bus_wdata[15:0];
            end else if (w_tick) begin
                r_presc <= r_dbr;
            end else begin
                r_presc <= r_presc - 16'd1;
            end
            if (w_tick) begin
                r_samp <= w_sync;
            end
        end
    end

    // IDR itself holds the filtered level; it only moves when two tick samples agree.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_filt
            assign w_filt[gi] = w_bypass ? w_sync[gi] :
                                (w_tick && (w_sync[gi] == r_samp[gi])) ? w_sync[gi] : r_idr[gi];
        end
    endgenerate
`else
    assign w_filt   = w_sync;
    assign w_dbr_rd = '0;
`endif

    assign w_rise  = r_idr & ~r_idr_d;
    assign w_fall  = ~r_idr & r_idr_d;
    assign w_qedge = r_primed ? ((w_rise & r_rier) | (w_fall & r_fier)) : '0;
    assign w_w1c   = (w_wr && (bus.bus_addr == ADDR_ISR)) ? w_wd : '0;
    assign w_sr    = |(r_isr & r_ier);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idr    <= '0;
            r_idr_d  <= '0;
            r_primed <= 1'b0;
        end else begin
            r_idr    <= w_filt;
            r_idr_d  <= r_idr;
            r_primed <= 1'b1;
        end
    end

    // A new qualified edge is ORed in after the clear, so it wins over a same-cycle W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cr   <= 1'b0;
            r_odr  <= '0;
            r_oenr <= '0;
            r_ier  <= '0;
            r_isr  <= '0;
            r_rier <= '0;
            r_fier <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_isr <= (r_isr & ~w_w1c) | w_qedge;
            r_irq <= r_cr & w_sr;
            if (w_wr) begin
                case (bus.bus_addr)
                    ADDR_CR:   r_cr   <= bus.bus_wdata[0];
                    ADDR_ODR:  r_odr  <= w_wd;
                    ADDR_BSR:  r_odr  <= r_odr | w_wd;
                    ADDR_BCR:  r_odr  <= r_odr & ~w_wd;
                    ADDR_IER:  r_ier  <= w_wd;
                    ADDR_RIER: r_rier <= w_wd;
                    ADDR_FIER: r_fier <= w_wd;
                    ADDR_OENR: r_oenr <= w_wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.bus_addr)
            ADDR_CR:   w_rdata[0]         = r_cr;
            ADDR_SR:   w_rdata[0]         = w_sr;
            ADDR_ODR:  w_rdata[WIDTH-1:0] = r_odr;
            ADDR_IDR:  w_rdata[WIDTH-1:0] = r_idr;
            ADDR_IER:  w_rdata[WIDTH-1:0] = r_ier;
            ADDR_ISR:  w_rdata[WIDTH-1:0] = r_isr;
            ADDR_RIER: w_rdata[WIDTH-1:0] = r_rier;
            ADDR_FIER: w_rdata[WIDTH-1:0] = r_fier;
            ADDR_OENR: w_rdata[WIDTH-1:0] = r_oenr;
            ADDR_DBR:  w_rdata            = w_dbr_rd;
            default:   w_rdata            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= bus.bus_req;
            r_rdata  <= w_rd ? w_rdata : '0;
        end
    end

    assign bus.bus_rvalid = r_rvalid;
    assign bus.bus_rdata  = r_rdata;
    assign gpio_out       = r_odr;
    assign gpio_oe        = r_oenr;
    assign irq            = r_irq;

endmodule

// File: tb/tb_gpio_ext.sv
// Bench for gpio_ext: table of register accesses, hand-timed interrupt sequences,
// and randomized traffic checked every cycle against a pin-history reference model.
`timescale 1ns/1ps
module tb_gpio_ext;

    localparam logic [11:0] A_CR   = 12'h000;
    localparam logic [11:0] A_SR   = 12'h004;
    localparam logic [11:0] A_ODR  = 12'h008;
    localparam logic [11:0] A_IDR  = 12'h00c;
    localparam logic [11:0] A_IER  = 12'h010;
    localparam logic [11:0] A_ISR  = 12'h014;
    localparam logic [11:0] A_RIER = 12'h018;
    localparam logic [11:0] A_FIER = 12'h01c;
    localparam logic [11:0] A_OENR = 12'h020;
    localparam logic [11:0] A_BSR  = 12'h024;
    localparam logic [11:0] A_BCR  = 12'h028;
    localparam logic [11:0] A_DBR  = 12'h02c;
    localparam logic [11:0] A_NONE = 12'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;
    logic [7:0]  gpio_in8;
    logic [7:0]  gpio_out8;
    logic [7:0]  gpio_oe8;
    logic        irq8;

    gpio_ext_if bif();
    gpio_ext_if bif8();

    gpio_ext #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus(bif),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_ext #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .bus(bif8),
        .gpio_in(gpio_in8), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_model;

    // Reference model: architectural registers plus a queue of pin samples (2-stage sync).
    logic [31:0] m_odr, m_oenr, m_ier, m_isr, m_rier, m_fier, m_idr, m_idr_d, m_rdata;
    logic        m_cr, m_irq, m_rvalid;
    logic [15:0] m_dbr;
    logic [31:0] pq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            A_CR:   return {31'd0, m_cr};
            A_SR:   return {31'd0, |(m_isr & m_ier)};
            A_ODR:  return m_odr;
            A_IDR:  return m_idr;
            A_IER:  return m_ier;
            A_ISR:  return m_isr;
            A_RIER: return m_rier;
            A_FIER: return m_fier;
            A_OENR: return m_oenr;
`ifdef GPIO_DEBOUNCE_EN
            A_DBR:  return {16'd0, m_dbr};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_odr = 0; m_oenr = 0; m_ier = 0; m_isr = 0; m_rier = 0; m_fier = 0;
        m_idr = 0; m_idr_d = 0; m_rdata = 0; m_cr = 0; m_irq = 0; m_rvalid = 0; m_dbr = 0;
        pq.delete();
        pq.push_back(32'd0);
        pq.push_back(32'd0);
    endtask

    task automatic model_step();
        logic [31:0] qe, w1c, wd, rd;
        logic        req, we;
        logic [11:0] a;
        if (rst) begin
            model_reset();
            return;
        end
        req = bif.bus_req; we = bif.bus_we; a = bif.bus_addr; wd = bif.bus_wdata;
        rd  = m_read(a);
        qe  = (m_idr & ~m_idr_d & m_rier) | (~m_idr & m_idr_d & m_fier);
        m_irq    = m_cr & (|(m_isr & m_ier));
        m_rvalid = req;
        m_rdata  = (req && !we) ? rd : 32'd0;
        w1c      = (req && we && a == A_ISR) ? wd : 32'd0;
        m_isr    = (m_isr & ~w1c) | qe;
        if (req && we) begin
            case (a)
                A_CR:   m_cr   = wd[0];
                A_ODR:  m_odr  = wd;
                A_BSR:  m_odr  = m_odr | wd;
                A_BCR:  m_odr  = m_odr & ~wd;
                A_IER:  m_ier  = wd;
                A_RIER: m_rier = wd;
                A_FIER: m_fier = wd;
                A_OENR: m_oenr = wd;
                A_DBR:  m_dbr  = wd[15:0];
                default: ;
            endcase
        end
        m_idr_d = m_idr;
        pq.push_back(gpio_in);
        m_idr = pq.pop_front();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        if (chk_model) begin
            check("m_gpio_out", gpio_out, m_odr);
            check("m_gpio_oe", gpio_oe, m_oenr);
            check("m_irq", 32'(irq), 32'(m_irq));
            check("m_rvalid", 32'(bif.bus_rvalid), 32'(m_rvalid));
            if (m_rvalid) check("m_rdata", bif.bus_rdata, m_rdata);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        bif.bus_req = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = a; bif.bus_wdata = d;
        tick();
        bif.bus_req = 1'b0; bif.bus_we = 1'b0;
        check("wr_rvalid", 32'(bif.bus_rvalid), 32'd1);
        $display("txn wr addr=%h data=%h", a, d);
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        bif.bus_req = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = a; bif.bus_wdata = 32'd0;
        tick();
        bif.bus_req = 1'b0;
        check("rd_rvalid", 32'(bif.bus_rvalid), 32'd1);
        d = bif.bus_rdata;
        $display("txn rd addr=%h data=%h", a, d);
    endtask

    task automatic bus8_write(input logic [11:0] a, input logic [31:0] d);
        bif8.bus_req = 1'b1; bif8.bus_we = 1'b1; bif8.bus_addr = a; bif8.bus_wdata = d;
        tick();
        bif8.bus_req = 1'b0; bif8.bus_we = 1'b0;
        $display("txn w8 wr addr=%h data=%h", a, d);
    endtask

    task automatic bus8_read(input logic [11:0] a, output logic [31:0] d);
        bif8.bus_req = 1'b1; bif8.bus_we = 1'b0; bif8.bus_addr = a; bif8.bus_wdata = 32'd0;
        tick();
        bif8.bus_req = 1'b0;
        d = bif8.bus_rdata;
        $display("txn w8 rd addr=%h data=%h", a, d);
    endtask

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    vec_t tbl[18];
    logic [11:0] addrs[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [11:0] a;
        int          lat;
        bit          seen;

        bif.bus_req = 0; bif.bus_we = 0; bif.bus_addr = 0; bif.bus_wdata = 0;
        bif8.bus_req = 0; bif8.bus_we = 0; bif8.bus_addr = 0; bif8.bus_wdata = 0;
        gpio_in = 32'd0; gpio_in8 = 8'd0;
        chk_model = 1'b1;
        model_reset();

        tbl[0]  = '{1'b1, A_ODR,  32'h0000_00F0, 32'h0,      32'hF0};
        tbl[1]  = '{1'b1, A_BSR,  32'h0000_000F, 32'h0,      32'hFF};
        tbl[2]  = '{1'b1, A_BCR,  32'h0000_0030, 32'h0,      32'hCF};
        tbl[3]  = '{1'b0, A_ODR,  32'h0,         32'hCF,     32'hCF};
        tbl[4]  = '{1'b0, A_BSR,  32'h0,         32'h0,      32'hCF};
        tbl[5]  = '{1'b0, A_BCR,  32'h0,         32'h0,      32'hCF};
        tbl[6]  = '{1'b1, A_CR,   32'hFFFF_FFFF, 32'h0,      32'hCF};
        tbl[7]  = '{1'b0, A_CR,   32'h0,         32'h1,      32'hCF};
        tbl[8]  = '{1'b1, A_OENR, 32'h0000_A5A5, 32'h0,      32'hCF};
        tbl[9]  = '{1'b0, A_OENR, 32'h0,         32'hA5A5,   32'hCF};
        tbl[10] = '{1'b1, A_NONE, 32'hFFFF_FFFF, 32'h0,      32'hCF};
        tbl[11] = '{1'b0, A_NONE, 32'h0,         32'h0,      32'hCF};
        tbl[12] = '{1'b1, A_IDR,  32'h0000_1234, 32'h0,      32'hCF};
        tbl[13] = '{1'b0, A_IDR,  32'h0,         32'h0,      32'hCF};
        tbl[14] = '{1'b0, A_DBR,  32'h0,         32'h0,      32'hCF};
        tbl[15] = '{1'b1, A_SR,   32'hFFFF_FFFF, 32'h0,      32'hCF};
        tbl[16] = '{1'b0, A_SR,   32'h0,         32'h0,      32'hCF};
        tbl[17] = '{1'b1, A_CR,   32'h0,         32'h0,      32'hCF};

        addrs = '{A_CR, A_SR, A_ODR, A_IDR, A_IER, A_ISR, A_RIER, A_FIER,
                  A_OENR, A_BSR, A_BCR, A_DBR, A_NONE};

        // Power-on reset and reset-state checks.
        repeat (3) tick();
        check("rst_out", gpio_out, 32'd0);
        check("rst_oe", gpio_oe, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rvalid", 32'(bif.bus_rvalid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].we) begin
                bus_write(tbl[i].addr, tbl[i].wdata);
            end else begin
                bus_read(tbl[i].addr, rd);
                check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            end
            check($sformatf("tbl%0d_gpio_out", i), gpio_out, tbl[i].exp_out);
        end

        // Reset with all pins high: IDR reaches all-ones after the third clock.
        gpio_in = 32'hFFFF_FFFF;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        bus_read(A_IDR, rd);
        check("idr_edge3", rd, 32'd0);
        bus_read(A_IDR, rd);
        check("idr_after3", rd, 32'hFFFF_FFFF);
        bus_read(A_ISR, rd);
        check("isr_after_rst", rd, 32'd0);
        check("irq_after_rst", 32'(irq), 32'd0);

        // Rising edge on pin 0 -> ISR at cycle 4, irq at cycle 5, W1C drops irq.
        gpio_in = 32'd0;
        repeat (5) tick();
        bus_write(A_ISR, 32'hFFFF_FFFF);
        bus_write(A_RIER, 32'h1);
        bus_write(A_IER, 32'h1);
        bus_write(A_CR, 32'h1);
        gpio_in = 32'h1;
        repeat (4) tick();
        check("irq_c4", 32'(irq), 32'd0);
        bus_read(A_ISR, rd);
        check("isr_c4", rd, 32'h1);
        check("irq_c5", 32'(irq), 32'd1);
        bus_write(A_ISR, 32'h1);
        check("irq_w1c_c1", 32'(irq), 32'd1);
        tick();
        check("irq_w1c_c2", 32'(irq), 32'd0);

        // Falling edge on pin 1 with IER masked, then unmasked.
        bus_write(A_RIER, 32'h0);
        gpio_in = 32'h3;
        repeat (5) tick();
        bus_write(A_ISR, 32'hFFFF_FFFF);
        bus_write(A_FIER, 32'h2);
        bus_write(A_IER, 32'h0);
        gpio_in = 32'h1;
        repeat (5) tick();
        bus_read(A_ISR, rd);
        check("fall_isr", rd, 32'h2);
        bus_read(A_SR, rd);
        check("fall_sr_masked", rd, 32'd0);
        check("fall_irq_masked", 32'(irq), 32'd0);
        bus_write(A_IER, 32'h2);
        bus_read(A_SR, rd);
        check("fall_sr_unmasked", rd, 32'd1);
        check("fall_irq_unmasked", 32'(irq), 32'd1);

        // W1C landing on the same edge as a new rising edge: set wins.
        bus_write(A_RIER, 32'h1);
        bus_write(A_ISR, 32'hFFFF_FFFF);
        gpio_in = 32'h0;
        repeat (5) tick();
        gpio_in = 32'h1;
        repeat (5) tick();
        gpio_in = 32'h0;
        repeat (5) tick();
        gpio_in = 32'h1;
        repeat (3) tick();
        bus_write(A_ISR, 32'h1);
        bus_read(A_ISR, rd);
        check("w1c_vs_set", rd, 32'h1);
        bus_write(A_ISR, 32'h1);
        bus_read(A_ISR, rd);
        check("w1c_plain", rd, 32'h0);

        // Asynchronous reset mid-operation clears irq and gpio_oe without a clock.
        bus_write(A_IER, 32'h3);
        bus_write(A_OENR, 32'hFF);
        gpio_in = 32'h0;
        repeat (5) tick();
        gpio_in = 32'h1;
        repeat (6) tick();
        check("pre_rst_irq", 32'(irq), 32'd1);
        check("pre_rst_oe", gpio_oe, 32'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("async_irq", 32'(irq), 32'd0);
        check("async_oe", gpio_oe, 32'd0);
        check("async_out", gpio_out, 32'd0);
        tick();
        rst = 1'b0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
            case ($urandom_range(0, 2))
                0: tick();
                1: begin
                    a = addrs[$urandom_range(0, 12)];
                    bus_read(a, rd);
                end
                default: begin
                    a = addrs[$urandom_range(0, 12)];
                    if (a == A_DBR) a = A_ISR;
                    bus_write(a, $urandom);
                end
            endcase
        end

`ifdef GPIO_DEBOUNCE_EN
        // Debounce with DBR = 9: a 5-cycle glitch is dropped, a held level passes.
        chk_model = 1'b0;
        gpio_in = 32'd0;
        bus_write(A_DBR, 32'd9);
        bus_read(A_DBR, rd);
        check("dbr_rd", rd, 32'd9);
        repeat (25) tick();
        gpio_in = 32'h8;
        repeat (5) tick();
        gpio_in = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus_read(A_IDR, rd);
            if (rd[3]) seen = 1'b1;
        end
        check("db_glitch", 32'(seen), 32'd0);
        gpio_in = 32'h8;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            bus_read(A_IDR, rd);
            if (rd[3] && lat < 0) lat = i;
        end
        check("db_latency", lat, (lat >= 12 && lat <= 24) ? lat : 32'hFFFF_FFFF);
        bus_write(A_DBR, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_model = 1'b1;
`endif

        // Narrow build: register bits above WIDTH-1 read 0.
        bus8_write(A_ODR, 32'hFFFF_FFFF);
        check("w8_gpio_out", 32'(gpio_out8), 32'hFF);
        bus8_read(A_ODR, rd);
        check("w8_odr", rd, 32'hFF);
        bus8_write(A_IER, 32'hFFFF_FFFF);
        bus8_read(A_IER, rd);
        check("w8_ier", rd, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
